sent_tx_control: RTL and testbench

//  Transmit-side control for the SENT link. Pops fast-channel words from the TX FIFO and packs them into

---
 rtl/sent_tx_control.sv | 188 ++++++++++++++++++
 tb/tb_sent_tx_control.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sent_tx_control.sv
// sent_tx_control
//   Transmit-side control for the SENT link. Pops fast-channel words from the
//   TX FIFO, packs them into six data nibbles according to the frame format,
//   multiplexes a 16-frame short serial message into status bits 3:2 and
//   presents one complete frame at a time to the TX pulse generator.
//
// Ports
//   clk_tx, reset_n_tx      clock (posedge) / async active-low reset
//   frame_format[2:0]       1=12_12 2=ONE_12 3=HS_ONE_12 4=SECURE
//                           5=SINGLE_12_0 6=14_10 7=16_8 0=off
//   fifo_empty_tx           TX FIFO empty
//   data_from_fifo_tx[11:0] FIFO read data, valid the cycle after a pop
//   read_enable_tx          one-cycle FIFO pop strobe
//   status_bits[1:0]        user status, sent in status nibble [1:0]
//   serial_load             capture id_serial/data_serial (ignored while busy)
//   id_serial, data_serial  short serial message contents
//   serial_busy             message captured or being sent
//   frame_ready             pulse generator accepts the frame
//   frame_valid             frame fields valid, held until frame_ready
//   status_nibble[3:0]      {start bit, serial bit, status_bits}
//   data_nibbles[23:0]      nibble1 at [23:20] .. nibble6 at [3:0]
//   nibble_count[2:0]       data nibbles to send: 6, or 4 for format 3
module sent_tx_control #(
  parameter int          SERIAL_FRAMES = 16,
  parameter logic [3:0]  CRC_SEED      = 4'b0101
) (
  input  logic        clk_tx,
  input  logic        reset_n_tx,
  input  logic [2:0]  frame_format,
  input  logic        fifo_empty_tx,
  input  logic [11:0] data_from_fifo_tx,
  output logic        read_enable_tx,
  input  logic [1:0]  status_bits,
  input  logic        serial_load,
  input  logic [3:0]  id_serial,
  input  logic [7:0]  data_serial,
  output logic        serial_busy,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [3:0]  status_nibble,
  output logic [23:0] data_nibbles,
  output logic [2:0]  nibble_count
);

  localparam logic [3:0] LAST_FRAME = 4'(SERIAL_FRAMES - 1);

  typedef enum logic [2:0] {IDLE, POP0, CAP0, POP1, CAP1, SEND} state_t;

  state_t      state, state_nx;
  logic [2:0]  fmt_q;
  logic [11:0] w0_q;
  logic        pop_d;       // a pop was issued last cycle, FIFO data is valid now
  logic [11:0] w0_src;
  logic [11:0] tail;
  logic [23:0] pack;
  logic        enter_send;
  logic        xfer;
  logic        frame_ser;   // the frame on the outputs carries a serial-message bit
  logic [3:0]  ser_cnt;
  logic [15:0] ser_msg;
  logic [3:0]  ser_idx;

  // Serial CRC-4, x^4+x^3+x^2+1, over id, data[7:4], data[3:0] and a trailing
  // zero nibble, MSB first.
  function automatic logic [3:0] crc4(input logic [11:0] msg);
    logic [15:0] bits;
    logic [3:0]  c;
    logic        fb;
    bits = {msg, 4'b0000};
    c    = CRC_SEED;
    for (int i = 15; i >= 0; i--) begin
      fb = c[3] ^ bits[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b1101 : 4'b0000);
    end
    return c;
  endfunction

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    read_enable_tx = 1'b0;
    case (state)
      IDLE: if (frame_format != 3'd0 && !fifo_empty_tx) state_nx = POP0;
      POP0: begin
        read_enable_tx = 1'b1;
        state_nx       = CAP0;
      end
      // Two-word formats wait here for the second word; a half frame is never sent.
      CAP0: begin
        if (fmt_q == 3'd2 || fmt_q == 3'd3) state_nx = SEND;
        else if (!fifo_empty_tx)            state_nx = POP1;
      end
      POP1: begin
        read_enable_tx = 1'b1;
        state_nx       = CAP1;
      end
      CAP1: state_nx = SEND;
      SEND: if (frame_valid && frame_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign enter_send = (state_nx == SEND) && (state != SEND);
  assign xfer       = frame_valid && frame_ready;

  // ---------------- word capture and packing ----------------
  // Fields are registered on the edge entering SEND, when the last word is
  // still on the FIFO read port, so that word is taken straight from the port.
  always_comb begin
    w0_src = (state == CAP0 && pop_d) ? data_from_fifo_tx : w0_q;
    case (fmt_q)
      3'd1, 3'd4, 3'd5: tail = {data_from_fifo_tx[3:0], data_from_fifo_tx[7:4],
                                data_from_fifo_tx[11:8]};
      3'd6:             tail = {2'b00, data_from_fifo_tx[1:0], data_from_fifo_tx[5:2],
                                data_from_fifo_tx[9:6]};
      3'd7:             tail = {data_from_fifo_tx[11:8], data_from_fifo_tx[3:0],
                                data_from_fifo_tx[7:4]};
      default:          tail = 12'h000;
    endcase
    pack = {w0_src, tail};
  end

  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      pop_d <= 1'b0;
      fmt_q <= 3'd0;
      w0_q  <= 12'h000;
    end else begin
      pop_d <= read_enable_tx;
      // Format is frozen for the whole frame.
      if (state == IDLE && state_nx == POP0) fmt_q <= frame_format;
      if (state == CAP0 && pop_d)            w0_q  <= data_from_fifo_tx;
    end
  end

  // ---------------- frame outputs ----------------
  assign ser_idx = 4'd15 - ser_cnt;

  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      frame_valid   <= 1'b0;
      frame_ser     <= 1'b0;
      status_nibble <= 4'h0;
      data_nibbles  <= 24'h0;
      nibble_count  <= 3'd0;
    end else if (enter_send) begin
      frame_valid   <= 1'b1;
      frame_ser     <= serial_busy;
      status_nibble <= {serial_busy && ser_cnt == 4'd0,
                        serial_busy && ser_msg[ser_idx],
                        status_bits};
      data_nibbles  <= pack;
      nibble_count  <= (fmt_q == 3'd3) ? 3'd4 : 3'd6;
    end else if (xfer) begin
      frame_valid <= 1'b0;
    end
  end

  // ---------------- short serial message ----------------
  // A message loaded while a frame is already on the outputs starts on the
  // following frame; frame_ser keeps that frame from advancing the counter.
  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      serial_busy <= 1'b0;
      ser_cnt     <= 4'd0;
      ser_msg     <= 16'h0;
    end else begin
      if (serial_load && !serial_busy) begin
        serial_busy <= 1'b1;
        ser_msg     <= {id_serial, data_serial, crc4({id_serial, data_serial})};
      end
      if (xfer && frame_ser) begin
        if (ser_cnt == LAST_FRAME) begin
          ser_cnt     <= 4'd0;
          serial_busy <= 1'b0;
        end else begin
          ser_cnt <= ser_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sent_tx_control.sv
module tb_sent_tx_control;

  logic        clk_tx = 1'b0;
  logic        reset_n_tx;
  logic [2:0]  frame_format;
  logic        fifo_empty_tx;
  logic [11:0] data_from_fifo_tx;
  logic        read_enable_tx;
  logic [1:0]  status_bits;
  logic        serial_load;
  logic [3:0]  id_serial;
  logic [7:0]  data_serial;
  logic        serial_busy;
  logic        frame_ready;
  logic        frame_valid;
  logic [3:0]  status_nibble;
  logic [23:0] data_nibbles;
  logic [2:0]  nibble_count;

  sent_tx_control dut (
    .clk_tx(clk_tx), .reset_n_tx(reset_n_tx), .frame_format(frame_format),
    .fifo_empty_tx(fifo_empty_tx), .data_from_fifo_tx(data_from_fifo_tx),
    .read_enable_tx(read_enable_tx), .status_bits(status_bits),
    .serial_load(serial_load), .id_serial(id_serial), .data_serial(data_serial),
    .serial_busy(serial_busy), .frame_ready(frame_ready), .frame_valid(frame_valid),
    .status_nibble(status_nibble), .data_nibbles(data_nibbles), .nibble_count(nibble_count)
  );

  always #5 clk_tx = ~clk_tx;

  typedef struct {
    logic [3:0]  st;
    logic [23:0] nib;
    logic [2:0]  cnt;
  } frame_t;

  typedef struct {
    logic [2:0]  fmt;
    logic [11:0] w0, w1;
    logic [1:0]  st;
    logic [23:0] nib;
    logic [2:0]  cnt;
    int          npop;
  } vec_t;

  frame_t      got[$];
  logic [11:0] fifo[$];
  int errors = 0, checks = 0, pops = 0, valid_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference packing: nibble extraction straight from the format rules.
  function automatic logic [23:0] model_pack(input int fmt, input int w0, input int w1);
    int n[6];
    int r;
    n[0] = (w0 >> 8) & 15; n[1] = (w0 >> 4) & 15; n[2] = w0 & 15;
    n[3] = 0; n[4] = 0; n[5] = 0;
    case (fmt)
      1, 4, 5: begin n[3] = w1 & 15;        n[4] = (w1 >> 4) & 15; n[5] = (w1 >> 8) & 15; end
      6:       begin n[3] = w1 & 3;         n[4] = (w1 >> 2) & 15; n[5] = (w1 >> 6) & 15; end
      7:       begin n[3] = (w1 >> 8) & 15; n[4] = w1 & 15;        n[5] = (w1 >> 4) & 15; end
      default: ;
    endcase
    r = 0;
    for (int i = 0; i < 6; i++) r = r | (n[i] << (4 * (5 - i)));
    return 24'(r);
  endfunction

  // Reference message: CRC as the remainder of polynomial long division by
  // x^4+x^3+x^2+1; the seed acts as an xor on the leading nibble.
  function automatic logic [15:0] model_msg(input logic [3:0] id, input logic [7:0] d);
    int v;
    v = (int'(id ^ 4'b0101) << 16) | (int'(d) << 8);
    for (int i = 19; i >= 4; i--)
      if (((v >> i) & 1) == 1) v = v ^ (32'h1D << (i - 4));
    return {id, d, 4'(v & 15)};
  endfunction

  function automatic logic [3:0] model_status(input bit ser, input logic [15:0] m,
                                              input int k, input logic [1:0] st);
    if (ser && k < 16) return {k == 0, m[15 - k], st};
    return {2'b00, st};
  endfunction

  task automatic push(input logic [11:0] w);
    fifo.push_back(w);
    fifo_empty_tx = 1'b0;
  endtask

  // One clock: observe outputs just before the edge, model the FIFO read port after it.
  task automatic step();
    logic   re;
    logic   hold;
    frame_t f;
    re    = read_enable_tx;
    if (re) pops++;
    if (frame_valid) valid_cycles++;
    f.st  = status_nibble; f.nib = data_nibbles; f.cnt = nibble_count;
    if (frame_valid && frame_ready) got.push_back(f);
    hold  = frame_valid && !frame_ready && reset_n_tx;
    @(posedge clk_tx); #1;
    if (re && fifo.size() > 0) data_from_fifo_tx = fifo.pop_front();
    fifo_empty_tx = (fifo.size() == 0);
    if (hold) begin
      chk("hold_valid", 32'(frame_valid), 32'd1);
      chk("hold_fields", 32'({status_nibble, data_nibbles, nibble_count}),
          32'({f.st, f.nib, f.cnt}));
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (got.size() < n && c < budget) begin step(); c++; end
    chk("frame_timeout", 32'(got.size()), 32'(n));
  endtask

  task automatic wait_valid(input int budget);
    int c = 0;
    while (!frame_valid && c < budget) begin step(); c++; end
    chk("valid_timeout", 32'(frame_valid), 32'd1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_re"},     32'(read_enable_tx), 32'd0);
    chk({tag, "_valid"},  32'(frame_valid),    32'd0);
    chk({tag, "_busy"},   32'(serial_busy),    32'd0);
    chk({tag, "_status"}, 32'(status_nibble),  32'd0);
    chk({tag, "_nib"},    32'(data_nibbles),   32'd0);
    chk({tag, "_cnt"},    32'(nibble_count),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[7];
    logic [15:0] msg;
    logic [11:0] pend[$];
    logic [11:0] words[$];
    frame_t      exp_f[$];

    reset_n_tx = 1'b0; frame_format = 3'd0; fifo_empty_tx = 1'b1; data_from_fifo_tx = 12'h0;
    status_bits = 2'b00; serial_load = 1'b0; id_serial = 4'h0; data_serial = 8'h0;
    frame_ready = 1'b0;

    // ---- reset state ----
    #12;
    chk_zero_outputs("reset");
    @(posedge clk_tx); #1;
    reset_n_tx = 1'b1;
    step();

    // ---- table of single frames ----
    tbl[0] = '{3'd1, 12'hABC, 12'h123, 2'b01, 24'hABC321, 3'd6, 2};
    tbl[1] = '{3'd7, 12'h5A7, 12'hC3E, 2'b10, 24'h5A7CE3, 3'd6, 2};
    tbl[2] = '{3'd6, 12'h800, 12'h3FD, 2'b00, 24'h8001FF, 3'd6, 2};
    tbl[3] = '{3'd3, 12'h9F0, 12'h000, 2'b11, 24'h9F0000, 3'd4, 1};
    tbl[4] = '{3'd2, 12'h777, 12'h000, 2'b01, 24'h777000, 3'd6, 1};
    tbl[5] = '{3'd4, 12'h246, 12'h8AC, 2'b10, 24'h246CA8, 3'd6, 2};
    tbl[6] = '{3'd5, 12'hFED, 12'h0F1, 2'b11, 24'hFED1F0, 3'd6, 2};
    frame_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      frame_format = tbl[i].fmt; status_bits = tbl[i].st;
      pops = 0; got.delete();
      push(tbl[i].w0);
      if (tbl[i].npop == 2) push(tbl[i].w1);
      wait_frames(1, 40);
      if (got.size() > 0) begin
        chk($sformatf("tbl%0d_nib", i),    32'(got[0].nib), 32'(tbl[i].nib));
        chk($sformatf("tbl%0d_cnt", i),    32'(got[0].cnt), 32'(tbl[i].cnt));
        chk($sformatf("tbl%0d_status", i), 32'(got[0].st),  32'({2'b00, tbl[i].st}));
      end
      chk($sformatf("tbl%0d_pops", i), 32'(pops), 32'(tbl[i].npop));
      repeat (2) step();
    end

    // ---- format 0: no pops, no frames; the word is used once a format is set ----
    frame_format = 3'd0; status_bits = 2'b00; pops = 0; got.delete(); valid_cycles = 0;
    push(12'h4E1);
    repeat (10) step();
    chk("fmt0_pops",  32'(pops),         32'd0);
    chk("fmt0_valid", 32'(valid_cycles), 32'd0);
    frame_format = 3'd3;
    wait_frames(1, 40);
    if (got.size() > 0) chk("fmt0_after_nib", 32'(got[0].nib), 32'h4E1000);
    chk("fmt0_after_pops", 32'(pops), 32'd1);
    repeat (2) step();

    // ---- empty FIFO between the two pops, then hold with frame_ready low ----
    frame_format = 3'd1; status_bits = 2'b10; frame_ready = 1'b0;
    pops = 0; got.delete(); valid_cycles = 0;
    push(12'h789);
    repeat (10) step();
    chk("halfword_valid", 32'(valid_cycles), 32'd0);
    chk("halfword_pops",  32'(pops),         32'd1);
    push(12'h456);
    wait_valid(20);
    repeat (5) step();
    frame_ready = 1'b1;
    wait_frames(1, 10);
    if (got.size() > 0) begin
      chk("halfword_nib",    32'(got[0].nib), 32'h789654);
      chk("halfword_status", 32'(got[0].st),  32'h2);
    end
    chk("halfword_pops2", 32'(pops), 32'd2);
    repeat (2) step();

    // ---- 16-frame serial message ----
    frame_format = 3'd3; status_bits = 2'b11; frame_ready = 1'b1;
    id_serial = 4'h3; data_serial = 8'hA5; serial_load = 1'b1;
    step();
    serial_load = 1'b0;
    chk("ser_busy_set", 32'(serial_busy), 32'd1);
    msg = model_msg(4'h3, 8'hA5);
    for (int k = 0; k < 16; k++) begin
      got.delete();
      push(12'(k * 7 + 1));
      if (k < 15) begin
        wait_frames(1, 40);
      end else begin
        // load attempt coincides with the transfer of frame 15 and must be ignored
        frame_ready = 1'b0;
        wait_valid(40);
        frame_ready = 1'b1; serial_load = 1'b1; id_serial = 4'hF; data_serial = 8'hFF;
        step();
        serial_load = 1'b0;
      end
      if (got.size() > 0)
        chk($sformatf("ser_frame%0d_status", k), 32'(got[0].st),
            32'(model_status(1'b1, msg, k, 2'b11)));
      if (k == 8) chk("ser_busy_mid", 32'(serial_busy), 32'd1);
    end
    chk("ser_busy_clear", 32'(serial_busy), 32'd0);
    got.delete();
    push(12'h0AA);
    wait_frames(1, 40);
    if (got.size() > 0) chk("ser_after_status", 32'(got[0].st), 32'h3);
    chk("ser_after_busy", 32'(serial_busy), 32'd0);
    repeat (2) step();

    // ---- randomized runs against the reference model ----
    for (int r = 0; r < 6; r++) begin
      int          fmt, nfr, nw;
      bit          ser;
      logic [3:0]  rid;
      logic [7:0]  rdat;
      logic [1:0]  rst;
      int          c;
      fmt = int'($urandom_range(7, 1)); rst = 2'($urandom); ser = (r % 2) == 0;
      rid = 4'($urandom); rdat = 8'($urandom);
      nfr = 20; nw = (fmt == 2 || fmt == 3) ? 1 : 2;
      frame_format = 3'(fmt); status_bits = rst;
      msg = model_msg(rid, rdat);
      pend.delete(); words.delete(); exp_f.delete(); got.delete();
      for (int j = 0; j < nfr * nw; j++) words.push_back(12'($urandom));
      for (int j = 0; j < nfr; j++) begin
        frame_t e;
        e.nib = model_pack(fmt, int'(words[j * nw]), (nw == 2) ? int'(words[j * nw + 1]) : 0);
        e.cnt = (fmt == 3) ? 3'd4 : 3'd6;
        e.st  = model_status(ser, msg, j, rst);
        exp_f.push_back(e);
      end
      foreach (words[j]) pend.push_back(words[j]);
      if (ser) begin
        id_serial = rid; data_serial = rdat; serial_load = 1'b1;
        step();
        serial_load = 1'b0;
      end
      c = 0;
      while (got.size() < nfr && c < 3000) begin
        if (pend.size() > 0 && $urandom_range(2, 0) == 0) push(pend.pop_front());
        frame_ready = 1'($urandom_range(1, 0));
        step();
        c++;
      end
      chk($sformatf("rnd%0d_frames", r), 32'(got.size()), 32'(nfr));
      for (int j = 0; j < nfr && j < got.size(); j++)
        chk($sformatf("rnd%0d_f%0d", r, j), 32'({got[j].st, got[j].nib, got[j].cnt}),
            32'({exp_f[j].st, exp_f[j].nib, exp_f[j].cnt}));
      frame_ready = 1'b1;
      repeat (3) step();
      chk($sformatf("rnd%0d_busy", r), 32'(serial_busy), 32'd0);
    end

    // ---- reset while in CAP1 with a message pending ----
    frame_format = 3'd1; status_bits = 2'b01; frame_ready = 1'b1;
    id_serial = 4'h5; data_serial = 8'h3C; serial_load = 1'b1;
    step();
    serial_load = 1'b0;
    push(12'h111); push(12'h222);
    pops = 0;
    begin
      int c = 0;
      while (pops < 2 && c < 20) begin step(); c++; end
    end
    chk("cap1_pops", 32'(pops), 32'd2);
    reset_n_tx = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    step();
    reset_n_tx = 1'b1;
    got.delete();
    push(12'h3C5); push(12'hD2E);
    wait_frames(1, 40);
    if (got.size() > 0) begin
      chk("postreset_status", 32'(got[0].st),  32'h1);
      chk("postreset_nib",    32'(got[0].nib), 32'h3C5E2D);
    end
    chk("postreset_busy", 32'(serial_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
